dac_load_ctrl: RTL and testbench

DAC_LOAD_CTRL -- requirements
Module: dac_load_ctrl

---
 rtl/dac_pkg.sv | 17 +
 rtl/dac_settle_tmr.sv | 34 +++
 rtl/dac_load_ctrl.sv | 140 ++++++++++++++
 tb/tb_dac_load_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants for the serial DAC load controller: default widths,
// frame length and FSM state encodings.
package dac_pkg;

  localparam int unsigned VREF_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;
  // start + vref + data + parity
  localparam int unsigned FRAME_LEN  = VREF_W_DEF + DATA_W_DEF + 2;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StShVref = 3'd1;
  localparam logic [2:0] StShData = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StSettle = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

endpackage

// File: rtl/dac_settle_tmr.sv
// Loadable down-counter timing the DAC settle window; zero flags expiry.
module dac_settle_tmr #(
  parameter int unsigned W        = 5,
  parameter int unsigned LOAD_VAL = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(LOAD_VAL);
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dac_load_ctrl.sv
// Serial frame receiver that checks even parity, latches vref/data codes and
// holds the DAC latch enable for a fixed settle window.
module dac_load_ctrl
  import dac_pkg::*;
#(
  parameter int unsigned VREF_W     = VREF_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              sin_en,
  output logic [VREF_W-1:0] vref_q,
  output logic [DATA_W-1:0] data_q,
  output logic              dac_le,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned BitMax  = (VREF_W > DATA_W) ? VREF_W : DATA_W;
  localparam int unsigned BitCntW = (BitMax > 1) ? $clog2(BitMax) : 1;
  localparam int unsigned SettleW = $clog2(SETTLE_CYC + 1);

  logic [2:0]         state_q, state_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [VREF_W-1:0]  vref_sh_q, vref_sh_d, vref_d;
  logic [DATA_W-1:0]  data_sh_q, data_sh_d, data_d;
  logic               par_q, par_d;
  logic               err_d;
  logic               tmr_load, tmr_zero;

  // Loaded with SETTLE_CYC-1 so zero is seen on the last settle cycle.
  dac_settle_tmr #(
    .W        (SettleW),
    .LOAD_VAL (SETTLE_CYC - 1)
  ) u_settle_tmr (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .count (state_q == StSettle),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    vref_sh_d = vref_sh_q;
    data_sh_d = data_sh_q;
    par_d     = par_q;
    vref_d    = vref_q;
    data_d    = data_q;
    err_d     = 1'b0;
    tmr_load  = 1'b0;
    case (state_q)
      StIdle: begin
        if (sin_en && sin) begin
          state_d   = StShVref;
          bit_cnt_d = BitCntW'(VREF_W - 1);
          par_d     = 1'b0;
        end
      end
      StShVref: begin
        if (sin_en) begin
          vref_sh_d = VREF_W'({vref_sh_q, sin});
          par_d     = par_q ^ sin;
          if (bit_cnt_q == '0) begin
            state_d   = StShData;
            bit_cnt_d = BitCntW'(DATA_W - 1);
          end else begin
            bit_cnt_d = bit_cnt_q - BitCntW'(1);
          end
        end
      end
      StShData: begin
        if (sin_en) begin
          data_sh_d = DATA_W'({data_sh_q, sin});
          par_d     = par_q ^ sin;
          if (bit_cnt_q == '0) begin
            state_d   = StParity;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q - BitCntW'(1);
          end
        end
      end
      StParity: begin
        if (sin_en) begin
          if ((par_q ^ sin) == 1'b0) begin
            state_d  = StSettle;
            vref_d   = vref_sh_q;
            data_d   = data_sh_q;
            tmr_load = 1'b1;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
      end
      StSettle: begin
        if (tmr_zero) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      vref_sh_q <= '0;
      data_sh_q <= '0;
      par_q     <= 1'b0;
      vref_q    <= '0;
      data_q    <= '0;
      dac_le    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      vref_sh_q <= vref_sh_d;
      data_sh_q <= data_sh_d;
      par_q     <= par_d;
      vref_q    <= vref_d;
      data_q    <= data_d;
      dac_le    <= (state_d == StSettle);
      busy      <= (state_d != StIdle);
      done      <= (state_d == StDone);
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_dac_load_ctrl.sv
// Directed bench for dac_load_ctrl: default build plus a SETTLE_CYC=1 build.
module tb_dac_load_ctrl;
  import dac_pkg::*;

  localparam int unsigned S = 16;

  logic       clk = 1'b0;
  logic       rst, rst1, sin, sin_en;
  logic [3:0] vref_q, vref1;
  logic [7:0] data_q, data1;
  logic       dac_le, busy, done, err;
  logic       dac_le1, busy1, done1, err1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dac_load_ctrl #(.VREF_W(4), .DATA_W(8), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en),
    .vref_q(vref_q), .data_q(data_q), .dac_le(dac_le),
    .busy(busy), .done(done), .err(err)
  );

  dac_load_ctrl #(.VREF_W(4), .DATA_W(8), .SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst(rst1), .sin(sin), .sin_en(sin_en),
    .vref_q(vref1), .data_q(data1), .dac_le(dac_le1),
    .busy(busy1), .done(done1), .err(err1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic b, input logic en);
    sin    = b;
    sin_en = en;
    @(posedge clk);
    #1;
  endtask

  // In half-rate mode a dead cycle carrying the inverted bit follows each bit.
  task automatic send_frame(input logic [FRAME_LEN-1:0] f, input bit half);
    for (int i = FRAME_LEN - 1; i >= 0; i--) begin
      step(f[i], 1'b1);
      if (half && i != 0) step(~f[i], 1'b0);
    end
  endtask

  task automatic run_settle(input string tag, input logic hold);
    int le_cnt   = 1;
    int done_cnt = 0;
    int done_at  = -1;
    int idle_at  = -1;
    int bad      = 0;
    for (int k = 1; k <= 60; k++) begin
      step(hold, hold);
      if (dac_le) le_cnt++;
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      if (err) bad++;
      if (!busy) begin
        idle_at = k;
        break;
      end
    end
    check_eq({tag, "_le_cycles"}, le_cnt, S);
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_done_at"}, done_at, S);
    check_eq({tag, "_idle_at"}, idle_at, S + 1);
    check_eq({tag, "_no_err"}, bad, 0);
  endtask

  task automatic check_latched(input string tag, input logic [3:0] v, input logic [7:0] d);
    check_eq({tag, "_vref"}, vref_q, v);
    check_eq({tag, "_data"}, data_q, d);
    check_eq({tag, "_le"}, dac_le, 1'b1);
    check_eq({tag, "_busy"}, busy, 1'b1);
    check_eq({tag, "_done"}, done, 1'b0);
  endtask

  logic [FRAME_LEN-1:0] f;

  initial begin
    rst = 1'b1; rst1 = 1'b1; sin = 1'b0; sin_en = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
    check_eq("rst_vref", vref_q, 4'h0);
    check_eq("rst_data", data_q, 8'h00);
    check_eq("rst_le", dac_le, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);

    repeat (3) step(1'b0, 1'b1);
    check_eq("idle_zero_ignored", busy, 1'b0);

    // Good frame, continuous enable
    f = {1'b1, 4'hA, 8'h5C, 1'b0};
    send_frame(f, 1'b0);
    check_latched("good", 4'hA, 8'h5C);
    run_settle("good", 1'b0);

    // Same payload, bad parity
    f = {1'b1, 4'hA, 8'h5C, 1'b1};
    send_frame(f, 1'b0);
    check_eq("perr_err", err, 1'b1);
    check_eq("perr_done", done, 1'b0);
    check_eq("perr_le", dac_le, 1'b0);
    check_eq("perr_busy", busy, 1'b0);
    step(1'b0, 1'b0);
    check_eq("perr_err_pulse", err, 1'b0);

    // Different payload, bad parity: outputs must not move
    f = {1'b1, 4'h6, 8'h33, 1'b1};
    send_frame(f, 1'b0);
    check_eq("perr2_err", err, 1'b1);
    check_eq("perr2_vref", vref_q, 4'hA);
    check_eq("perr2_data", data_q, 8'h5C);
    step(1'b0, 1'b0);

    // Half bit rate
    f = {1'b1, 4'h1, 8'hFF, 1'b1};
    send_frame(f, 1'b1);
    check_latched("half", 4'h1, 8'hFF);
    run_settle("half", 1'b0);

    // Abort a frame after six bits
    f = {1'b1, 4'hF, 8'hAA, 1'b0};
    for (int i = FRAME_LEN - 1; i >= FRAME_LEN - 6; i--) step(f[i], 1'b1);
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    check_eq("abort_vref", vref_q, 4'h0);
    check_eq("abort_data", data_q, 8'h00);
    check_eq("abort_busy", busy, 1'b0);
    f = {1'b1, 4'h3, 8'h01, 1'b1};
    send_frame(f, 1'b0);
    check_latched("after_abort", 4'h3, 8'h01);
    run_settle("after_abort", 1'b0);

    // Reset in the middle of the settle window
    f = {1'b1, 4'h9, 8'h42, 1'b0};
    send_frame(f, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    check_eq("midsettle_le", dac_le, 1'b0);
    check_eq("midsettle_busy", busy, 1'b0);
    check_eq("midsettle_vref", vref_q, 4'h0);
    check_eq("midsettle_data", data_q, 8'h00);

    // Start bits held through SETTLE and DONE must not be captured
    f = {1'b1, 4'h5, 8'hC3, 1'b0};
    send_frame(f, 1'b0);
    check_latched("hold", 4'h5, 8'hC3);
    run_settle("hold", 1'b1);
    step(1'b0, 1'b0);
    check_eq("hold_idle", busy, 1'b0);
    check_eq("hold_vref", vref_q, 4'h5);
    f = {1'b1, 4'h2, 8'h81, 1'b1};
    send_frame(f, 1'b0);
    check_latched("post_hold", 4'h2, 8'h81);
    run_settle("post_hold", 1'b0);

    // SETTLE_CYC=1 build
    rst1 = 1'b0;
    step(1'b0, 1'b0);
    f = {1'b1, 4'hA, 8'h5C, 1'b0};
    send_frame(f, 1'b0);
    check_eq("s1_vref", vref1, 4'hA);
    check_eq("s1_data", data1, 8'h5C);
    check_eq("s1_le", dac_le1, 1'b1);
    check_eq("s1_done0", done1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("s1_le_off", dac_le1, 1'b0);
    check_eq("s1_done", done1, 1'b1);
    check_eq("s1_err", err1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("s1_done_pulse", done1, 1'b0);
    check_eq("s1_idle", busy1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
